// File: rtl/muldiv_issue_if.sv
// rtl/muldiv_issue_if.sv - Issue-side bus between muldiv_issue and the multiply/divide unit

interface muldiv_issue_if;
  logic        md_used;
  logic [2:0]  md_control;
  logic [31:0] md_srca;
  logic [31:0] md_srcb;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  modport master (
    output md_used, md_control, md_srca, md_srcb,
    input  md_busy, md_hi, md_lo
  );

  modport slave (
    input  md_used, md_control, md_srca, md_srcb,
    output md_busy, md_hi, md_lo
  );
endinterface

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - Mul/div issue FIFO and HI/LO hazard control; MD_ISSUE_STATS_EN enables the stall counter

module muldiv_issue #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_a,
  input  logic [31:0]   req_b,
  input  logic          rd_req,
  input  logic          rd_hi,
  output logic [31:0]   rd_data,
  output logic          stall,
  muldiv_issue_if.master md,
  output logic [31:0]   stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // IDLE: free to issue; HOLD: mul/div on md_used, unit busy not yet visible;
  // BUSY: waiting for the unit to drop busy.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_BUSY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    fifo_op_q [DEPTH];
  logic [2:0]    fifo_op_d [DEPTH];
  logic [31:0]   fifo_a_q  [DEPTH];
  logic [31:0]   fifo_a_d  [DEPTH];
  logic [31:0]   fifo_b_q  [DEPTH];
  logic [31:0]   fifo_b_d  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          md_used_q, md_used_d;
  logic [2:0]    md_control_q, md_control_d;
  logic [31:0]   md_srca_q, md_srca_d;
  logic [31:0]   md_srcb_q, md_srcb_d;

  logic          req_legal;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          issue;
  logic          rd_ready;
  logic [2:0]    head_op;

  assign req_legal  = (req_op != 3'd0) && (req_op != 3'd7);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head_op    = fifo_op_q[rd_ptr_q];
  // Pushing is gated only on the current full flag; a same-cycle pop does not free a slot early.
  assign push       = req_valid && req_legal && !fifo_full;
  assign issue      = !fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_BUSY) && !md.md_busy));

  // Reads of HI/LO are safe only once nothing is queued, launching, or in flight.
  assign rd_ready = fifo_empty && !md_used_q && !md.md_busy && (state_q != S_HOLD);
  assign stall    = (rd_req && !rd_ready) || (req_valid && req_legal && fifo_full);
  assign rd_data  = rd_hi ? md.md_hi : md.md_lo;

  assign md.md_used    = md_used_q;
  assign md.md_control = md_control_q;
  assign md.md_srca    = md_srca_q;
  assign md.md_srcb    = md_srcb_q;

  // Next-state for FIFO, issue FSM and the registered unit-side outputs.
  always_comb begin
    state_d      = state_q;
    fifo_op_d    = fifo_op_q;
    fifo_a_d     = fifo_a_q;
    fifo_b_d     = fifo_b_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    md_used_d    = 1'b0;
    md_control_d = md_control_q;
    md_srca_d    = md_srca_q;
    md_srcb_d    = md_srcb_q;

    if (push) begin
      fifo_op_d[wr_ptr_q] = req_op;
      fifo_a_d[wr_ptr_q]  = req_a;
      fifo_b_d[wr_ptr_q]  = req_b;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end

    if (issue) begin
      md_used_d    = 1'b1;
      md_control_d = head_op;
      md_srca_d    = fifo_a_q[rd_ptr_q];
      md_srcb_d    = fifo_b_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + PW'(1);
      // mul/div must pass through HOLD so busy has a cycle to appear.
      state_d      = (head_op <= 3'd4) ? S_HOLD : S_IDLE;
    end else begin
      case (state_q)
        S_HOLD:  state_d = S_BUSY;
        S_BUSY:  state_d = md.md_busy ? S_BUSY : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    count_d = count_q + CW'(push) - CW'(issue);
  end

  // State registers; reset drops all queued ops with no unit handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_op_q[i] <= '0;
        fifo_a_q[i]  <= '0;
        fifo_b_q[i]  <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      md_used_q    <= 1'b0;
      md_control_q <= '0;
      md_srca_q    <= '0;
      md_srcb_q    <= '0;
    end else begin
      state_q      <= state_d;
      fifo_op_q    <= fifo_op_d;
      fifo_a_q     <= fifo_a_d;
      fifo_b_q     <= fifo_b_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      md_used_q    <= md_used_d;
      md_control_q <= md_control_d;
      md_srca_q    <= md_srca_d;
      md_srcb_q    <= md_srcb_d;
    end
  end

`ifdef MD_ISSUE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_muldiv_issue.sv
// tb/tb_muldiv_issue.sv - Self-checking bench for muldiv_issue with a mul/div unit stub and reference model

module tb_muldiv_issue;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rd_req;
  logic        rd_hi;
  logic [31:0] rd_data;
  logic        stall;
  logic [31:0] stall_cnt;

  muldiv_issue_if md_bus ();

  muldiv_issue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rd_req    (rd_req),
    .rd_hi     (rd_hi),
    .rd_data   (rd_data),
    .stall     (stall),
    .md        (md_bus.master),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural HI/LO effect of one op: returns {hi, lo}.
  function automatic logic [63:0] md_calc(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
    longint          sp;
    longint unsigned up;
    int              sq;
    int              sr;
    md_calc = {hi, lo};
    case (op)
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); md_calc = sp; end
      3'd2: begin up = 64'(a) * 64'(b); md_calc = up; end
      3'd3: begin sq = $signed(a) / $signed(b); sr = $signed(a) % $signed(b); md_calc = {sr, sq}; end
      3'd4: md_calc = {a % b, a / b};
      3'd5: md_calc = {a, lo};
      3'd6: md_calc = {hi, a};
      default: md_calc = {hi, lo};
    endcase
  endfunction

  // Multiply/divide unit stub: busy rises the edge after md_used, 5 cycles for mul, 10 for div.
  logic        u_busy;
  logic [3:0]  u_cnt;
  logic [31:0] u_hi, u_lo, u_phi, u_plo;
  assign md_bus.md_busy = u_busy;
  assign md_bus.md_hi   = u_hi;
  assign md_bus.md_lo   = u_lo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_busy <= 1'b0; u_cnt <= '0; u_hi <= '0; u_lo <= '0; u_phi <= '0; u_plo <= '0;
    end else begin
      if (u_busy) begin
        u_cnt <= u_cnt - 4'd1;
        if (u_cnt == 4'd1) begin
          u_busy <= 1'b0; u_hi <= u_phi; u_lo <= u_plo;
        end
      end
      if (md_bus.md_used) begin
        if (md_bus.md_control <= 3'd4) begin
          u_busy <= 1'b1;
          u_cnt  <= (md_bus.md_control >= 3'd3) ? 4'd10 : 4'd5;
          {u_phi, u_plo} <= md_calc(md_bus.md_control, md_bus.md_srca, md_bus.md_srcb, u_hi, u_lo);
        end else begin
          {u_hi, u_lo} <= md_calc(md_bus.md_control, md_bus.md_srca, md_bus.md_srcb, u_hi, u_lo);
        end
      end
    end
  end

  // Reference model: pending-op queue, predicted launch, HI/LO contents, stall count.
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  ent_t        mq[$];
  logic        m_issue_next;
  logic [31:0] m_hi, m_lo;
  int          m_stall_cnt;
  logic        m_accept;
  logic        m_rd_done;
  logic [31:0] m_rd_val;

  always @(negedge clk) begin
    ent_t        e;
    logic        exp_used, hold, legal, full_m, ready_m, exp_stall;
    logic [31:0] exp_cnt;
    if (!reset) begin
      mq.delete();
      m_issue_next = 1'b0; m_hi = '0; m_lo = '0; m_stall_cnt = 0;
      m_accept = 1'b0; m_rd_done = 1'b0; m_rd_val = '0;
    end else begin
      exp_used = m_issue_next;
      hold     = 1'b0;
      check("md_used", md_bus.md_used, exp_used);
      check("used_while_busy", md_bus.md_used && md_bus.md_busy, 0);
      if (exp_used && mq.size() > 0) begin
        e = mq.pop_front();
        check("md_control", md_bus.md_control, e.op);
        check("md_srca", md_bus.md_srca, e.a);
        check("md_srcb", md_bus.md_srcb, e.b);
        {m_hi, m_lo} = md_calc(e.op, e.a, e.b, m_hi, m_lo);
        hold = (e.op <= 3'd4);
      end
      legal     = (req_op >= 3'd1) && (req_op <= 3'd6);
      full_m    = (mq.size() == DEPTH);
      ready_m   = (mq.size() == 0) && !exp_used && !md_bus.md_busy && !hold;
      exp_stall = (rd_req && !ready_m) || (req_valid && legal && full_m);
      check("stall", stall, exp_stall);
`ifdef MD_ISSUE_STATS_EN
      exp_cnt = 32'(m_stall_cnt);
`else
      exp_cnt = 32'd0;
`endif
      check("stall_cnt", stall_cnt, exp_cnt);
      m_rd_done = rd_req && !exp_stall;
      if (m_rd_done) begin
        m_rd_val = rd_data;
        check("rd_data", rd_data, rd_hi ? m_hi : m_lo);
      end
      m_accept     = req_valid && !(legal && full_m);
      m_issue_next = (mq.size() > 0) && !hold && !md_bus.md_busy;
      if (req_valid && legal && !full_m) mq.push_back('{req_op, req_a, req_b});
      if (exp_stall) m_stall_cnt++;
    end
  end

  // Drivers: all called and returning at posedge + 1.
  task automatic push_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int waited);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_accept && n < 300);
    check("push_accept", m_accept, 1);
    req_valid = 1'b0; req_op = 3'd0;
    waited = n;
  endtask

  task automatic read_op(input logic hi, output logic [31:0] val, output int waited);
    int n = 0;
    rd_req = 1'b1; rd_hi = hi;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_rd_done && n < 300);
    check("read_done", m_rd_done, 1);
    rd_req = 1'b0;
    val = m_rd_val;
    waited = n;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          w, w3;
    logic [31:0] v, a, b;
    logic [2:0]  op;
    req_valid = 0; req_op = 0; req_a = 0; req_b = 0; rd_req = 0; rd_hi = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_used", md_bus.md_used, 0);
    check("rst_control", md_bus.md_control, 0);
    check("rst_srca", md_bus.md_srca, 0);
    check("rst_srcb", md_bus.md_srcb, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_stall", stall, 0);
    reset = 1'b1;
    idle(2);

    // multu 3*5, then mflo waits for the unit
    push_op(3'd2, 32'd3, 32'd5, w);
    read_op(1'b0, v, w);
    check("mflo_multu", v, 32'd15);
    check("mflo_stalled", w > 1, 1);

    // div -7/2 followed immediately by mtlo 9
    push_op(3'd3, 32'hFFFF_FFF9, 32'd2, w);
    push_op(3'd6, 32'd9, 32'd0, w);
    read_op(1'b0, v, w);
    check("mflo_after_mtlo", v, 32'd9);
    read_op(1'b1, v, w);
    check("mfhi_div_rem", v, 32'hFFFF_FFFF);

    // mthi/mtlo back-to-back on an idle unit
    push_op(3'd5, 32'h11, 32'd0, w);
    push_op(3'd6, 32'h22, 32'd0, w);
    idle(3);
    read_op(1'b1, v, w);
    check("mfhi_mthi", v, 32'h11);
    check("mfhi_no_stall", w, 1);
    read_op(1'b0, v, w);
    check("mflo_mtlo", v, 32'h22);

    // fill the FIFO behind a busy unit; third mult must wait for a pop
    push_op(3'd4, 32'd100, 32'd7, w);
    push_op(3'd1, 32'd2, 32'd3, w);
    push_op(3'd1, 32'd4, 32'd5, w);
    push_op(3'd1, 32'hFFFF_FFFE, 32'd6, w3);
    check("full_stalls_pusher", w3 > 1, 1);
    read_op(1'b0, v, w);
    check("mflo_last_mult", v, 32'hFFFF_FFF4);

    // reset while busy with two ops queued
    push_op(3'd3, 32'd1000, 32'd9, w);
    push_op(3'd1, 32'd7, 32'd7, w);
    push_op(3'd2, 32'd8, 32'd8, w);
    idle(2);
    reset = 1'b0;
    #1;
    check("midrst_used", md_bus.md_used, 0);
    check("midrst_stall", stall, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    push_op(3'd5, 32'h55, 32'd0, w);
    check("post_rst_push", w, 1);
    read_op(1'b1, v, w);
    check("post_rst_mfhi", v, 32'h55);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          op = 3'($urandom_range(1, 6));
          a  = $urandom;
          b  = $urandom;
          if (op == 3'd3 || op == 3'd4) begin
            b = 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
          end
          push_op(op, a, b, w);
        end
        6, 7: read_op(1'($urandom_range(0, 1)), v, w);
        8: idle($urandom_range(0, 3));
        default: push_op(($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0, $urandom, $urandom, w);
      endcase
    end
    idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
